traffic_ctrl_n: RTL and testbench
=================================

Name: traffic_ctrl_n

Overview:
Parametrised N-approach traffic-signal controller. It generalises the two-road Ta/Tb controller to N_DIR approaches served round-robin. It adds programmable minimum green, maximum green, yellow and all-red intervals, and emergency pre-emption. It is a Moore machine, and every light output comes straight from a register.

Parameters:
N_DIR, 4, number of approaches (>=2)
MIN_GREEN, 4, minimum green length in cycles (>=1)
MAX_GREEN, 10, green length in cycles after which a waiting approach forces a change (>=MIN_GREEN)
YELLOW_CYC, 3, yellow length in cycles (>=1)
ALL_RED_CYC, 1, all-red clearance length in cycles (0 = no all-red state)
Derived localparams: DIR_W = max(1, clog2(N_DIR)); CNT_W = clog2(max(MAX_GREEN, YELLOW_CYC, ALL_RED_CYC)+1)

Ports:
clk  input  1  system clock
Reset  input  1  synchronous, active-high reset
T  input  N_DIR  traffic present; T[i] = approach i has a waiting or arriving vehicle
Emerg  input  1  emergency pre-emption request
EmergDir  input  DIR_W  approach to pre-empt for; values >= N_DIR make Emerg ignored
L  output  2*N_DIR  light for approach i is L[2*i+1:2*i]; 0=green, 1=yellow, 2=red, 3 is never driven
CurDir  output  DIR_W  approach currently owning green, yellow or clearance

Behaviour:
- Single clock domain; all state updates on posedge clk. Reset is synchronous and active-high and overrides everything.
- Reset state: state=GREEN, cur=0, cnt=0. L = approach 0 green, all others red. CurDir=0. These values are visible the cycle after Reset is sampled high.
- States: GREEN, YELLOW, ALLRED. Only approach cur is non-red. Every other approach is red in all states, and in ALLRED every approach is red.
- cnt is cleared on entry to each state and increments once per cycle.
  - In GREEN, cnt saturates at MAX_GREEN-1.
- Definitions:
  - other = OR of T[j] for j != cur.
  - emv = Emerg && EmergDir < N_DIR.
  - hold = emv && EmergDir==cur.
  - preempt = emv && EmergDir!=cur.
- GREEN -> YELLOW (cnt<=0) when any one of the following holds:
  - preempt (this ignores MIN_GREEN);
  - !hold && other && !T[cur] && cnt>=MIN_GREEN-1;
  - !hold && other && cnt>=MAX_GREEN-1.
  - Otherwise GREEN holds. With no competing demand, or during hold, green lasts indefinitely.
- GREEN duration: the minimum visible green is MIN_GREEN cycles (except under preempt); the maximum is MAX_GREEN cycles when another approach is waiting.
- YELLOW: lasts exactly YELLOW_CYC cycles.
  - Next state is ALLRED if ALL_RED_CYC>0; otherwise next direction selection applies directly.
  - Never truncated by Emerg, T or anything else except Reset.
- ALLRED: lasts exactly ALL_RED_CYC cycles, then GREEN with cur<=next and cnt<=0.
- Next direction selection, evaluated in the last YELLOW/ALLRED cycle from the inputs sampled in that cycle:
  - if emv, next = EmergDir;
  - else next = the first index cyclically after cur (cur+1, ..., wrapping past N_DIR-1 to 0, with cur last) whose T is 1;
  - if no T bit is set, next = (cur+1) mod N_DIR.
- CurDir = cur and changes only on entry to GREEN.
- Simultaneous events:
  - Emerg asserting at the exact cycle green would time out is handled as preempt/hold; the result is the same transition or hold.
  - Emerg dropping during YELLOW/ALLRED falls back to round-robin selection at selection time.
- Reset mid-operation: any state returns to the reset state on the next edge; there is no partial yellow.
- Inputs are assumed synchronous to clk; no internal synchronisers.

Test Plan:
All scenarios use N_DIR=4, MIN_GREEN=4, MAX_GREEN=10, YELLOW_CYC=3, ALL_RED_CYC=1. Cycle 0 is the first cycle after Reset is released.
- Reset, T=4'b0000 for 50 cycles -> L=8'b10_10_10_00 (approach 0 green) throughout, CurDir=0.
- Reset, then T=4'b0100 held -> approach 0 green for cycles 0-3, yellow (L[1:0]=1) cycles 4-6, all red cycle 7, approach 2 green from cycle 8 with CurDir=2; approaches 1 and 3 are skipped.
- T=4'b0011 held from reset -> approach 0 green for exactly 10 cycles (MAX_GREEN), 3 yellow, 1 all-red, then approach 1 green.
- Wrap-around: cur=3 green, T=4'b0101 with T[3]=0, and cnt>=3 -> yellow, all-red, then approach 0 green (not approach 2).
- Emergency: approach 0 green at cnt=1, Emerg=1, EmergDir=2, T=0 -> yellow next cycle, then 3 yellow and 1 all-red, then approach 2 green. Approach 2 holds green for 30+ cycles while Emerg=1 even with T=4'b1011. Once Emerg drops, it yields MIN_GREEN rules apply with cnt already saturated, so yellow follows next cycle.
- Reset asserted during the second YELLOW cycle of approach 1 -> next cycle L=8'b10_10_10_00 and CurDir=0. A repeat with EmergDir=3'b?? >= 4 (DIR_W=2, so test N_DIR=3, EmergDir=3) leaves Emerg with no effect.

Source files
------------

// File: rtl/traffic_ctrl_n.sv
// traffic_ctrl_n
// Round-robin traffic-signal controller for N_DIR approaches. One approach at a
// time owns the junction and steps through green, yellow and an optional
// all-red clearance. Green length is bounded below by MIN_GREEN and, when
// another approach is waiting, above by MAX_GREEN. An emergency request can cut
// a green short (pre-emption) or keep the requested approach green (hold).
// All light outputs are registered, so the controller is a pure Moore machine.
//
// Ports:
//   clk      - system clock, all state updates on the rising edge
//   Reset    - synchronous active-high reset, overrides everything
//   T        - per-approach traffic present flags
//   Emerg    - emergency pre-emption request
//   EmergDir - approach to pre-empt for; values >= N_DIR make Emerg ignored
//   L        - light pair per approach, L[2*i+1:2*i]: 0=green 1=yellow 2=red
//   CurDir   - approach currently owning green, yellow or clearance
module traffic_ctrl_n #(
  parameter int N_DIR       = 4,
  parameter int MIN_GREEN   = 4,
  parameter int MAX_GREEN   = 10,
  parameter int YELLOW_CYC  = 3,
  parameter int ALL_RED_CYC = 1,
  localparam int DIR_W = (N_DIR > 1) ? $clog2(N_DIR) : 1
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic [N_DIR-1:0]     T,
  input  logic                 Emerg,
  input  logic [DIR_W-1:0]     EmergDir,
  output logic [2*N_DIR-1:0]   L,
  output logic [DIR_W-1:0]     CurDir
);

  localparam int CNT_TOP0 = (MAX_GREEN > YELLOW_CYC) ? MAX_GREEN : YELLOW_CYC;
  localparam int CNT_TOP  = (CNT_TOP0 > ALL_RED_CYC) ? CNT_TOP0 : ALL_RED_CYC;
  localparam int CNT_W    = $clog2(CNT_TOP + 1);

  // Last counter value of each timed interval.
  localparam logic [CNT_W-1:0] GREEN_MIN_LAST = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] GREEN_MAX_LAST = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST    = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST    = CNT_W'(ALL_RED_CYC - 1);

  localparam logic [1:0] LT_GREEN  = 2'b00;
  localparam logic [1:0] LT_YELLOW = 2'b01;
  localparam logic [1:0] LT_RED    = 2'b10;

  typedef enum logic [1:0] {
    ST_GREEN  = 2'd0,
    ST_YELLOW = 2'd1,
    ST_ALLRED = 2'd2
  } state_t;

  state_t                state_r, state_nxt_s;
  logic [DIR_W-1:0]      cur_r, cur_nxt_s;
  logic [CNT_W-1:0]      cnt_r, cnt_nxt_s;
  logic [2*N_DIR-1:0]    light_r, light_nxt_s;
  logic                  other_s;
  logic                  emv_s;
  logic                  hold_s;
  logic                  preempt_s;
  logic                  go_yellow_s;
  logic [DIR_W-1:0]      sel_dir_s;
  logic [31:0]           emerg_dir_ext_s;

  // Light pattern for a given state and owning approach; non-owners are red.
  function automatic logic [2*N_DIR-1:0] lights(input state_t st,
                                                input logic [DIR_W-1:0] cur);
    logic [2*N_DIR-1:0] r;
    r = {N_DIR{LT_RED}};
    for (int i = 0; i < N_DIR; i++) begin
      if (i == int'(cur)) begin
        case (st)
          ST_GREEN:  r[2*i +: 2] = LT_GREEN;
          ST_YELLOW: r[2*i +: 2] = LT_YELLOW;
          default:   r[2*i +: 2] = LT_RED;
        endcase
      end else begin
        r[2*i +: 2] = LT_RED;
      end
    end
    return r;
  endfunction

  // True when some approach other than cur has traffic.
  function automatic logic any_other(input logic [DIR_W-1:0] cur,
                                     input logic [N_DIR-1:0] t);
    logic r;
    r = 1'b0;
    for (int j = 0; j < N_DIR; j++) begin
      if ((j != int'(cur)) && t[j]) begin
        r = 1'b1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Round-robin pick: first requesting approach after cur, cur itself last;
  // with no requests at all the turn simply passes to cur+1.
  function automatic logic [DIR_W-1:0] rr_pick(input logic [DIR_W-1:0] cur,
                                               input logic [N_DIR-1:0] t);
    logic [DIR_W-1:0] r;
    logic             found;
    int               idx;
    r     = DIR_W'((int'(cur) + 1) % N_DIR);
    found = 1'b0;
    for (int s = 1; s <= N_DIR; s++) begin
      idx = (int'(cur) + s) % N_DIR;
      if (!found && t[idx]) begin
        r     = DIR_W'(idx);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return r;
  endfunction

  // Decode emergency request, competing demand and the green exit condition.
  always_comb begin
    emerg_dir_ext_s = 32'(EmergDir);
    emv_s           = Emerg && (emerg_dir_ext_s < 32'(N_DIR));
    hold_s          = emv_s && (EmergDir == cur_r);
    preempt_s       = emv_s && (EmergDir != cur_r);
    other_s         = any_other(cur_r, T);
    go_yellow_s     = preempt_s ||
                      (!hold_s && other_s &&
                       ((!T[cur_r] && (cnt_r >= GREEN_MIN_LAST)) ||
                        (cnt_r >= GREEN_MAX_LAST)));
    if (emv_s) begin
      sel_dir_s = EmergDir;
    end else begin
      sel_dir_s = rr_pick(cur_r, T);
    end
  end

  // Next-state, next-owner, interval counter and next light pattern.
  always_comb begin
    state_nxt_s = state_r;
    cur_nxt_s   = cur_r;
    cnt_nxt_s   = cnt_r + CNT_W'(1);
    case (state_r)
      ST_GREEN: begin
        if (go_yellow_s) begin
          state_nxt_s = ST_YELLOW;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else if (cnt_r >= GREEN_MAX_LAST) begin
          cnt_nxt_s = cnt_r;  // saturate: keeps the max-green test armed
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_YELLOW: begin
        if (cnt_r == YELLOW_LAST) begin
          cnt_nxt_s = {CNT_W{1'b0}};
          if (ALL_RED_CYC > 0) begin
            state_nxt_s = ST_ALLRED;
          end else begin
            state_nxt_s = ST_GREEN;
            cur_nxt_s   = sel_dir_s;
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_ALLRED: begin
        if (cnt_r == ALLRED_LAST) begin
          state_nxt_s = ST_GREEN;
          cur_nxt_s   = sel_dir_s;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        // Unreachable encoding: fall back to the reset condition.
        state_nxt_s = ST_GREEN;
        cur_nxt_s   = {DIR_W{1'b0}};
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
    endcase
    light_nxt_s = lights(state_nxt_s, cur_nxt_s);
  end

  // State, owner, counter and light registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_r <= ST_GREEN;
      cur_r   <= {DIR_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      light_r <= lights(ST_GREEN, {DIR_W{1'b0}});
    end else begin
      state_r <= state_nxt_s;
      cur_r   <= cur_nxt_s;
      cnt_r   <= cnt_nxt_s;
      light_r <= light_nxt_s;
    end
  end

  assign L      = light_r;
  assign CurDir = cur_r;

endmodule

// File: tb/tb_traffic_ctrl_n.sv
// Testbench for traffic_ctrl_n. Drives a 4-approach and a 3-approach instance
// from shared inputs, compares both against a timing-rule model every cycle,
// and pins the model with hand-computed light patterns for directed scenarios.
module tb_traffic_ctrl_n;

  localparam int MIN_G = 4;
  localparam int MAX_G = 10;
  localparam int YEL   = 3;
  localparam int AR    = 1;

  logic       clk;
  logic       Reset;
  logic [3:0] T;
  logic       Emerg;
  logic [1:0] EmergDir;
  logic [7:0] L4;
  logic [1:0] cur4;
  logic [5:0] L3;
  logic [1:0] cur3;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  // Model state per instance: phase 0=green 1=yellow 2=all-red, owner,
  // and number of cycles already spent in the phase before the current one.
  int m_ph  [2];
  int m_cur [2];
  int m_el  [2];

  traffic_ctrl_n #(.N_DIR(4)) dut4 (
    .clk(clk), .Reset(Reset), .T(T), .Emerg(Emerg), .EmergDir(EmergDir),
    .L(L4), .CurDir(cur4)
  );

  traffic_ctrl_n #(.N_DIR(3)) dut3 (
    .clk(clk), .Reset(Reset), .T(T[2:0]), .Emerg(Emerg), .EmergDir(EmergDir),
    .L(L3), .CurDir(cur3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  // One clock of the controller rules, expressed as elapsed-time tests.
  task automatic model_step(input int k, input int n, input logic [3:0] t,
                            input logic em, input int ed, input logic rst);
    bit emv, hold, pre, other, leave;
    int nxt;
    if (rst) begin
      m_ph[k] = 0; m_cur[k] = 0; m_el[k] = 0;
    end else begin
      emv   = em && (ed < n);
      hold  = emv && (ed == m_cur[k]);
      pre   = emv && (ed != m_cur[k]);
      other = 1'b0;
      for (int j = 0; j < n; j++) if (j != m_cur[k] && t[j]) other = 1'b1;
      nxt = (m_cur[k] + 1) % n;
      for (int s = n; s >= 1; s--) if (t[(m_cur[k] + s) % n]) nxt = (m_cur[k] + s) % n;
      if (emv) nxt = ed;
      case (m_ph[k])
        0: begin
          leave = pre || (!hold && other &&
                  ((!t[m_cur[k]] && (m_el[k] + 1 >= MIN_G)) || (m_el[k] + 1 >= MAX_G)));
          if (leave) begin m_ph[k] = 1; m_el[k] = 0; end
          else m_el[k]++;
        end
        1: begin
          if (m_el[k] + 1 == YEL) begin
            m_el[k] = 0;
            if (AR > 0) m_ph[k] = 2;
            else begin m_ph[k] = 0; m_cur[k] = nxt; end
          end else m_el[k]++;
        end
        default: begin
          if (m_el[k] + 1 == AR) begin
            m_ph[k] = 0; m_cur[k] = nxt; m_el[k] = 0;
          end else m_el[k]++;
        end
      endcase
    end
  endtask

  function automatic logic [7:0] exp_l(input int k, input int n);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < n; i++)
      r[2*i +: 2] = (i == m_cur[k]) ? 2'(m_ph[k]) : 2'd2;
    return r;
  endfunction

  // Advance the model with the inputs the DUTs sample on this edge.
  always @(posedge clk) begin
    model_step(0, 4, T, Emerg, int'(EmergDir), Reset);
    model_step(1, 3, {1'b0, T[2:0]}, Emerg, int'(EmergDir), Reset);
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_L4", {24'd0, L4}, {24'd0, exp_l(0, 4)});
      check("model_cur4", {30'd0, cur4}, 32'(m_cur[0]));
      check("model_L3", {26'd0, L3}, {24'd0, exp_l(1, 3)});
      check("model_cur3", {30'd0, cur3}, 32'(m_cur[1]));
    end
  end

  task automatic do_reset(input logic [3:0] t, input logic em, input logic [1:0] ed);
    @(negedge clk);
    Reset = 1'b1; T = t; Emerg = em; EmergDir = ed;
    @(negedge clk);
    Reset  = 1'b0;
    chk_en = 1'b1;
    cyc    = 0;
  endtask

  task automatic go_to(input int c);
    while (cyc < c) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    Reset = 1'b0; T = 4'b0000; Emerg = 1'b0; EmergDir = 2'd0;

    // Idle: approach 0 stays green indefinitely.
    do_reset(4'b0000, 1'b0, 2'd0);
    check("idle_L_c0", {24'd0, L4}, 32'h0000_00A8);
    check("idle_cur_c0", {30'd0, cur4}, 32'd0);
    go_to(49);
    check("idle_L_c49", {24'd0, L4}, 32'h0000_00A8);
    check("idle_L3_c49", {26'd0, L3}, 32'h0000_0028);

    // Single request on approach 2: min green, yellow, all-red, skip 1 and 3.
    do_reset(4'b0100, 1'b0, 2'd0);
    go_to(3);  check("req2_green_c3", {24'd0, L4}, 32'h0000_00A8);
    go_to(4);  check("req2_yel_c4", {24'd0, L4}, 32'h0000_00A9);
    go_to(6);  check("req2_yel_c6", {24'd0, L4}, 32'h0000_00A9);
    go_to(7);  check("req2_allred_c7", {24'd0, L4}, 32'h0000_00AA);
    go_to(8);  check("req2_green2_c8", {24'd0, L4}, 32'h0000_008A);
    check("req2_cur_c8", {30'd0, cur4}, 32'd2);
    check("req2_L3_c8", {26'd0, L3}, 32'h0000_000A);

    // Own traffic present: green runs to MAX_GREEN.
    do_reset(4'b0011, 1'b0, 2'd0);
    go_to(9);  check("max_green_c9", {24'd0, L4}, 32'h0000_00A8);
    go_to(10); check("max_yel_c10", {24'd0, L4}, 32'h0000_00A9);
    go_to(13); check("max_allred_c13", {24'd0, L4}, 32'h0000_00AA);
    go_to(14); check("max_green1_c14", {24'd0, L4}, 32'h0000_00A2);
    check("max_cur_c14", {30'd0, cur4}, 32'd1);

    // Wrap-around from approach 3 to approach 0.
    do_reset(4'b1000, 1'b0, 2'd0);
    go_to(8);  check("wrap_green3_c8", {24'd0, L4}, 32'h0000_002A);
    check("wrap_cur3_c8", {30'd0, cur4}, 32'd3);
    T = 4'b0101;
    go_to(11); check("wrap_green3_c11", {24'd0, L4}, 32'h0000_002A);
    go_to(12); check("wrap_yel3_c12", {24'd0, L4}, 32'h0000_006A);
    go_to(15); check("wrap_allred_c15", {24'd0, L4}, 32'h0000_00AA);
    go_to(16); check("wrap_green0_c16", {24'd0, L4}, 32'h0000_00A8);
    check("wrap_cur0_c16", {30'd0, cur4}, 32'd0);

    // Emergency pre-emption to approach 2, hold, then release.
    do_reset(4'b0000, 1'b0, 2'd0);
    go_to(1);  Emerg = 1'b1; EmergDir = 2'd2;
    go_to(2);  check("emg_yel_c2", {24'd0, L4}, 32'h0000_00A9);
    go_to(5);  check("emg_allred_c5", {24'd0, L4}, 32'h0000_00AA);
    go_to(6);  check("emg_green2_c6", {24'd0, L4}, 32'h0000_008A);
    check("emg_cur2_c6", {30'd0, cur4}, 32'd2);
    T = 4'b1011;
    go_to(40); check("emg_hold_c40", {24'd0, L4}, 32'h0000_008A);
    go_to(41); Emerg = 1'b0;
    go_to(42); check("emg_rel_yel_c42", {24'd0, L4}, 32'h0000_009A);
    go_to(46); check("emg_next3_c46", {24'd0, L4}, 32'h0000_002A);
    check("emg_cur3_c46", {30'd0, cur4}, 32'd3);

    // Reset during the second yellow cycle of approach 1.
    do_reset(4'b0010, 1'b0, 2'd0);
    go_to(8);  check("rst_green1_c8", {24'd0, L4}, 32'h0000_00A2);
    T = 4'b0001;
    go_to(13); check("rst_yel1_c13", {24'd0, L4}, 32'h0000_00A6);
    check("rst_yel1_L3_c13", {26'd0, L3}, 32'h0000_0026);
    Reset = 1'b1;
    go_to(14); check("rst_mid_L_c14", {24'd0, L4}, 32'h0000_00A8);
    check("rst_mid_cur_c14", {30'd0, cur4}, 32'd0);

    // Out-of-range EmergDir on the 3-approach instance is ignored.
    do_reset(4'b0010, 1'b1, 2'd3);
    go_to(4);  check("oor_yel_L3_c4", {26'd0, L3}, 32'h0000_0029);
    go_to(8);  check("oor_green1_L3_c8", {26'd0, L3}, 32'h0000_0022);
    check("oor_cur3_c8", {30'd0, cur3}, 32'd1);
    check("oor_dut4_pre_c8", {24'd0, L4}, 32'h0000_002A);
    T = 4'b0001;
    go_to(13); check("oor_yel1_L3_c13", {26'd0, L3}, 32'h0000_0026);
    Reset = 1'b1;
    go_to(14); check("oor_rst_L3_c14", {26'd0, L3}, 32'h0000_0028);
    check("oor_rst_cur3_c14", {30'd0, cur3}, 32'd0);
    Reset = 1'b0;
    go_to(16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
